mcu_bus_transmitter: RTL and testbench
======================================

// Module: mcu_bus_transmitter
// PURPOSE
//  Host-side driver of the 8-bit MCU bus into the GPU's message broker: takes command bytes and
//  12-bit pixels over valid/ready and emits them as strobed bus beats (mcu_bus_clock,
//  mcu_bus_command_data). Used in the MCU-emulation/loopback build and as the bus source in benches.
//  Top level owns the tristate: mcu_bus = mcu_bus_oe ? mcu_bus_out : 8'bz.
// PARAMETERS
//  SETUP_CYCLES  2  cycles data/flag driven with strobe low before rising edge (>=1)
//  HIGH_CYCLES   2  cycles strobe high; >=2 so the receiver's 2-FF synchroniser catches it
//  HOLD_CYCLES   1  cycles strobe low with data still driven after falling edge (>=1)
//  Any parameter <1 is an elaboration error ($error in initial block).
// PORTS
//  system_clock          in   1   sole clock
//  reset                 in   1   synchronous, active-high
//  cmd_valid             in   1   command byte available
//  cmd_data              in   8   command code (codes from commands.v)
//  cmd_ready             out  1   command accepted on cmd_valid&&cmd_ready
//  pix_valid             in   1   pixel available
//  pix_data              in   12  pixel {R[3:0],G[3:0],B[3:0]}
//  pix_ready             out  1   pixel accepted on pix_valid&&pix_ready
//  mcu_bus_out           out  8   bus byte
//  mcu_bus_oe            out  1   drive enable for mcu_bus
//  mcu_bus_clock         out  1   beat strobe; receiver latches on its rising edge
//  mcu_bus_command_data  out  1   1 = command beat, 0 = pixel beat
//  busy                  out  1   state != IDLE
//  beat_count            out  16  completed beats, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (any cycle, incl. mid-beat): state=IDLE; mcu_bus_clock=0, mcu_bus_oe=0, mcu_bus_out=0,
//   mcu_bus_command_data=0, beat_count=0, busy=0; cmd_ready=pix_ready=0 while reset is high.
//   In-flight item discarded; a half-sent pixel is not replayed (host re-syncs by command).
//  FSM: IDLE -> SETUP -> HIGH -> HOLD -> (SETUP for 2nd pixel beat | IDLE).
//  IDLE: cmd_ready = !reset; pix_ready = !reset && !cmd_valid (command has priority, same cycle
//   both valid -> command taken, pixel held). Accept registers item and beats_left; -> SETUP.
//  Cycle after accept: oe=1, bus/flag valid, strobe 0. SETUP_CYCLES later strobe=1 for
//   HIGH_CYCLES, then strobe=0 for HOLD_CYCLES; bus/flag stable from SETUP start to HOLD end.
//  Command: 1 beat, flag=1, byte=cmd_data.
//  Pixel: 2 beats, flag=0; beat0 = pix_data[7:0], beat1 = {4'b0, pix_data[11:8]}.
//  beat_count increments on last HOLD cycle of every beat.
//  Leaving HOLD to IDLE: oe=0, strobe=0 next cycle; IDLE lasts >=1 cycle, so with defaults accepts
//   recur every 6 cycles (command) / 11 cycles (pixel). Strobe never glitches; all outputs registered
//   except cmd_ready/pix_ready (decoded from state, reset, cmd_valid).
//  Phase counter sized $clog2(max param)+1; reloads on every phase change.
//  Inputs ignored outside IDLE; cmd_data/pix_data may change freely after acceptance.
// STRUCTURE
//  commands.v: command codes (CMD_START_VGA = 8'd2), shared by broker and this block.
//  Package/header: bus beat field widths, FSM state localparams (IDLE/SETUP/HIGH/HOLD).
//  One natural sub-module: bus_phase_timer (load count, down-count, done pulse); rest is flat.
// TESTING
//  1 Reset 3 cycles, cmd_valid=1 cmd_data=0x02 -> one strobe high 2 cycles, flag=1, bus=0x02,
//    beat_count=1, busy low after 6th cycle; receiver model decodes "start VGA".
//  2 pix 12'hABC -> beats 0xBC then 0x0A, flag=0 both, beat_count=2, pix_ready back after 11 cycles.
//  3 cmd_valid and pix_valid same cycle -> command sent first, pix_ready=0 that cycle, pixel next.
//  4 Reset asserted during HIGH of pixel beat0 -> next edge strobe=0, oe=0, beat_count=0, no beat1.
//  5 Preload beat_count 0xFFFF via 65535 commands (or force) + 1 beat -> beat_count=0.
//  6 Stream 640 pixels back-to-back into broker model -> 1280 beats, data matches, strobe high
//    width always exactly HIGH_CYCLES, bus stable whole strobe-high window.

Source files
------------

// File: rtl/mcu_bus_transmitter_pkg.sv
// Shared definitions for the host-side MCU bus transmitter: bus field widths,
// FSM states and the command codes understood by the GPU message broker.
package mcu_bus_transmitter_pkg;

  localparam int BUS_WIDTH        = 8;
  localparam int PIXEL_WIDTH      = 12;
  localparam int PIXEL_HIGH_WIDTH = PIXEL_WIDTH - BUS_WIDTH;
  localparam int BEAT_COUNT_WIDTH = 16;

  // Command codes shared with the broker
  localparam logic [BUS_WIDTH-1:0] CMD_START_VGA = 8'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    HOLD  = 2'd3
  } bus_state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_bus_transmitter_if.sv
// Host handshake plus MCU bus beat signals; master is the item source,
// slave is the transmitter that turns items into strobed beats.
interface mcu_bus_transmitter_if;
  import mcu_bus_transmitter_pkg::*;

  logic                   cmd_valid;
  logic [BUS_WIDTH-1:0]   cmd_data;
  logic                   cmd_ready;
  logic                   pix_valid;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_ready;
  logic [BUS_WIDTH-1:0]   mcu_bus_out;
  logic                   mcu_bus_oe;
  logic                   mcu_bus_clock;
  logic                   mcu_bus_command_data;

  modport master (
    output cmd_valid, cmd_data, pix_valid, pix_data,
    input  cmd_ready, pix_ready,
    input  mcu_bus_out, mcu_bus_oe, mcu_bus_clock, mcu_bus_command_data
  );

  modport slave (
    input  cmd_valid, cmd_data, pix_valid, pix_data,
    output cmd_ready, pix_ready,
    output mcu_bus_out, mcu_bus_oe, mcu_bus_clock, mcu_bus_command_data
  );

endinterface

// File: rtl/mcu_bus_transmitter_bus_phase_timer.sv
// Down-counter timing one bus phase: load with (cycles-1) on phase entry,
// done is high during the final cycle of the phase.
module bus_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mcu_bus_transmitter.sv
// Host-side MCU bus driver: accepts command bytes and 12-bit pixels and emits
// them as setup/strobe-high/hold bus beats (one per command, two per pixel).
module mcu_bus_transmitter
  import mcu_bus_transmitter_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                        system_clock,
  input  logic                        reset,
  mcu_bus_transmitter_if.slave        bus,
  output logic                        busy,
  output logic [BEAT_COUNT_WIDTH-1:0] beat_count
);

  localparam int MAX_CYCLES = max_of3(SETUP_CYCLES, HIGH_CYCLES, HOLD_CYCLES);
  localparam int PHASE_W    = $clog2(MAX_CYCLES) + 1;

  localparam logic [PHASE_W-1:0] SETUP_LOAD = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HIGH_LOAD  = PHASE_W'(HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("SETUP_CYCLES must be at least 1");
  end
  if (HIGH_CYCLES < 1) begin : g_bad_high
    $error("HIGH_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end

  bus_state_t                  state;
  bus_state_t                  state_next;
  logic                        timer_load;
  logic [PHASE_W-1:0]          timer_value;
  logic                        timer_done;
  logic                        accept_cmd;
  logic                        accept_pix;
  logic                        start_second_beat;
  logic                        beat_done;
  logic                        cmd_ready_c;
  logic                        pix_ready_c;
  logic                        second_beat_pending;
  logic [PIXEL_HIGH_WIDTH-1:0] pix_high;
  logic [BUS_WIDTH-1:0]        bus_byte;
  logic                        bus_flag;
  logic                        bus_strobe;
  logic                        bus_oe;
  logic                        busy_q;
  logic [BEAT_COUNT_WIDTH-1:0] beat_count_q;

  bus_phase_timer #(
    .WIDTH (PHASE_W)
  ) u_phase_timer (
    .system_clock (system_clock),
    .reset        (reset),
    .load         (timer_load),
    .load_value   (timer_value),
    .done         (timer_done)
  );

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Commands win over pixels when both are offered in the same idle cycle
  always_comb begin
    state_next        = state;
    timer_load        = 1'b0;
    timer_value       = '0;
    accept_cmd        = 1'b0;
    accept_pix        = 1'b0;
    start_second_beat = 1'b0;
    beat_done         = 1'b0;
    cmd_ready_c       = (state == IDLE) && !reset;
    pix_ready_c       = (state == IDLE) && !reset && !bus.cmd_valid;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_c) begin
          accept_cmd  = 1'b1;
          state_next  = SETUP;
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
        end else if (bus.pix_valid && pix_ready_c) begin
          accept_pix  = 1'b1;
          state_next  = SETUP;
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (timer_done) begin
          state_next  = HIGH;
          timer_load  = 1'b1;
          timer_value = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (timer_done) begin
          state_next  = HOLD;
          timer_load  = 1'b1;
          timer_value = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (timer_done) begin
          beat_done = 1'b1;
          if (second_beat_pending) begin
            start_second_beat = 1'b1;
            state_next        = SETUP;
            timer_load        = 1'b1;
            timer_value       = SETUP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so the strobe cannot glitch
  always_ff @(posedge system_clock) begin
    if (reset) begin
      bus_byte            <= '0;
      bus_flag            <= 1'b0;
      bus_strobe          <= 1'b0;
      bus_oe              <= 1'b0;
      busy_q              <= 1'b0;
      beat_count_q        <= '0;
      second_beat_pending <= 1'b0;
      pix_high            <= '0;
    end else begin
      bus_strobe <= (state_next == HIGH);
      bus_oe     <= (state_next != IDLE);
      busy_q     <= (state_next != IDLE);
      if (accept_cmd) begin
        bus_byte            <= bus.cmd_data;
        bus_flag            <= 1'b1;
        second_beat_pending <= 1'b0;
      end else if (accept_pix) begin
        bus_byte            <= bus.pix_data[BUS_WIDTH-1:0];
        bus_flag            <= 1'b0;
        second_beat_pending <= 1'b1;
        pix_high            <= bus.pix_data[PIXEL_WIDTH-1:BUS_WIDTH];
      end else if (start_second_beat) begin
        bus_byte            <= {{(BUS_WIDTH-PIXEL_HIGH_WIDTH){1'b0}}, pix_high};
        second_beat_pending <= 1'b0;
      end
      if (beat_done) begin
        beat_count_q <= beat_count_q + 1'b1;
      end
    end
  end

  assign bus.cmd_ready            = cmd_ready_c;
  assign bus.pix_ready            = pix_ready_c;
  assign bus.mcu_bus_out          = bus_byte;
  assign bus.mcu_bus_oe           = bus_oe;
  assign bus.mcu_bus_clock        = bus_strobe;
  assign bus.mcu_bus_command_data = bus_flag;
  assign busy                     = busy_q;
  assign beat_count               = beat_count_q;

endmodule

// File: tb/tb_mcu_bus_transmitter.sv
// Directed bench for mcu_bus_transmitter: vector table of single items plus
// hand sequences for priority, mid-beat reset, counter wrap and a pixel stream.
module tb_mcu_bus_transmitter;
  import mcu_bus_transmitter_pkg::*;

  localparam int HIGH_CYCLES = 2;
  localparam int NUM_VECS    = 7;
  localparam int NUM_STREAM  = 640;

  typedef struct {
    bit          is_cmd;
    logic [11:0] data;
    int          nbeats;
    logic [8:0]  beat0;
    logic [8:0]  beat1;
  } vec_t;

  logic        system_clock = 1'b0;
  logic        reset        = 1'b1;
  logic        busy;
  logic [15:0] beat_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  logic [8:0] seen_beats[$];
  logic [8:0] exp_beats[$];
  bit         relax_width = 1'b0;
  logic       prev_strobe = 1'b0;
  logic [8:0] cur_beat    = '0;
  int         high_len    = 0;

  vec_t vecs[NUM_VECS];

  mcu_bus_transmitter_if bus ();

  mcu_bus_transmitter dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .beat_count   (beat_count)
  );

  always #5 system_clock = ~system_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting, wanted event", name);
  endtask

  // Receiver model: captures each beat on the strobe rising edge, checks width and stability
  always @(negedge system_clock) begin
    if (bus.mcu_bus_clock === 1'b1) begin
      if (prev_strobe !== 1'b1) begin
        cur_beat = {bus.mcu_bus_command_data, bus.mcu_bus_out};
        seen_beats.push_back(cur_beat);
        high_len = 1;
        checkOutput("oe during strobe", 32'(bus.mcu_bus_oe), 32'd1);
      end else begin
        high_len++;
        checkOutput("bus stable while strobe high",
                    32'({bus.mcu_bus_command_data, bus.mcu_bus_out}), 32'(cur_beat));
      end
    end else if (prev_strobe === 1'b1 && !relax_width) begin
      checkOutput("strobe high width", 32'(high_len), 32'(HIGH_CYCLES));
    end
    prev_strobe = bus.mcu_bus_clock;
  end

  task automatic applyStimulus(input bit is_cmd, input logic [11:0] data);
    int n;
    @(negedge system_clock);
    if (is_cmd) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = data[7:0];
    end else begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = data;
    end
    #1;
    n = 0;
    while (!(is_cmd ? bus.cmd_ready : bus.pix_ready) && n < 100) begin
      @(negedge system_clock);
      #1;
      n++;
    end
    if (n >= 100) reportTimeout("accept");
    @(posedge system_clock);
    @(negedge system_clock);
    bus.cmd_valid = 1'b0;
    bus.pix_valid = 1'b0;
    bus.cmd_data  = ~data[7:0];
    bus.pix_data  = ~data;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge system_clock);
      n++;
    end
    if (n >= 200) reportTimeout("busy to drop");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles;
    int n;
    logic [11:0] pix;

    vecs[0] = '{1'b1, 12'h002, 1, {1'b1, CMD_START_VGA}, 9'h000};
    vecs[1] = '{1'b0, 12'hABC, 2, 9'h0BC, 9'h00A};
    vecs[2] = '{1'b1, 12'h0FF, 1, 9'h1FF, 9'h000};
    vecs[3] = '{1'b0, 12'h000, 2, 9'h000, 9'h000};
    vecs[4] = '{1'b0, 12'hFFF, 2, 9'h0FF, 9'h00F};
    vecs[5] = '{1'b1, 12'h000, 1, 9'h100, 9'h000};
    vecs[6] = '{1'b0, 12'h5A3, 2, 9'h0A3, 9'h005};

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;

    // Reset state, including handshakes held off while reset is high
    repeat (3) @(negedge system_clock);
    checkOutput("reset strobe", 32'(bus.mcu_bus_clock), 32'd0);
    checkOutput("reset oe", 32'(bus.mcu_bus_oe), 32'd0);
    checkOutput("reset bus_out", 32'(bus.mcu_bus_out), 32'd0);
    checkOutput("reset flag", 32'(bus.mcu_bus_command_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset beat_count", 32'(beat_count), 32'd0);
    checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("reset pix_ready", 32'(bus.pix_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Command timing: bus valid the cycle after accept, ready again 6 cycles later
    seen_beats.delete();
    applyStimulus(1'b1, 12'h002);
    checkOutput("cmd setup oe", 32'(bus.mcu_bus_oe), 32'd1);
    checkOutput("cmd setup strobe", 32'(bus.mcu_bus_clock), 32'd0);
    checkOutput("cmd setup bus", 32'(bus.mcu_bus_out), 32'(CMD_START_VGA));
    checkOutput("cmd setup flag", 32'(bus.mcu_bus_command_data), 32'd1);
    cycles = 1;
    while (!bus.cmd_ready && cycles < 50) begin
      @(negedge system_clock);
      cycles++;
    end
    checkOutput("cmd recurrence cycles", 32'(cycles), 32'd6);
    checkOutput("cmd idle oe", 32'(bus.mcu_bus_oe), 32'd0);
    checkOutput("cmd idle busy", 32'(busy), 32'd0);
    exp_count += 1;
    checkOutput("cmd start_vga beats", 32'(seen_beats.size()), 32'd1);
    if (seen_beats.size() > 0)
      checkOutput("cmd start_vga decode", 32'(seen_beats[0]), 32'({1'b1, CMD_START_VGA}));
    checkOutput("cmd beat_count", 32'(beat_count), 32'(exp_count));

    // Pixel timing: ready again 11 cycles after accept
    seen_beats.delete();
    applyStimulus(1'b0, 12'hABC);
    cycles = 1;
    while (!bus.pix_ready && cycles < 50) begin
      @(negedge system_clock);
      cycles++;
    end
    checkOutput("pix recurrence cycles", 32'(cycles), 32'd11);
    exp_count += 2;
    checkOutput("pix beat_count", 32'(beat_count), 32'(exp_count));

    // Table of single items
    for (int i = 0; i < NUM_VECS; i++) begin
      seen_beats.delete();
      applyStimulus(vecs[i].is_cmd, vecs[i].data);
      waitIdle();
      exp_count += vecs[i].nbeats;
      checkOutput($sformatf("vec%0d beats", i), 32'(seen_beats.size()), 32'(vecs[i].nbeats));
      if (seen_beats.size() > 0)
        checkOutput($sformatf("vec%0d beat0", i), 32'(seen_beats[0]), 32'(vecs[i].beat0));
      if (vecs[i].nbeats > 1 && seen_beats.size() > 1)
        checkOutput($sformatf("vec%0d beat1", i), 32'(seen_beats[1]), 32'(vecs[i].beat1));
      checkOutput($sformatf("vec%0d beat_count", i), 32'(beat_count), 32'(exp_count));
    end

    // Command and pixel offered together: command first, pixel held then sent
    seen_beats.delete();
    @(negedge system_clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h11;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 12'h123;
    #1;
    checkOutput("prio pix_ready", 32'(bus.pix_ready), 32'd0);
    checkOutput("prio cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge system_clock);
    @(negedge system_clock);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.pix_ready && n < 100) begin
      @(negedge system_clock);
      n++;
    end
    if (n >= 100) reportTimeout("prio pixel accept");
    @(posedge system_clock);
    @(negedge system_clock);
    bus.pix_valid = 1'b0;
    waitIdle();
    exp_count += 3;
    checkOutput("prio beats", 32'(seen_beats.size()), 32'd3);
    if (seen_beats.size() == 3) begin
      checkOutput("prio beat0 cmd", 32'(seen_beats[0]), 32'h111);
      checkOutput("prio beat1 pix lo", 32'(seen_beats[1]), 32'h023);
      checkOutput("prio beat2 pix hi", 32'(seen_beats[2]), 32'h001);
    end
    checkOutput("prio beat_count", 32'(beat_count), 32'(exp_count));

    // Reset while the first pixel beat strobe is high
    seen_beats.delete();
    relax_width = 1'b1;
    applyStimulus(1'b0, 12'hABC);
    n = 0;
    while (bus.mcu_bus_clock !== 1'b1 && n < 50) begin
      @(negedge system_clock);
      n++;
    end
    if (n >= 50) reportTimeout("strobe high before reset");
    reset = 1'b1;
    @(posedge system_clock);
    @(negedge system_clock);
    checkOutput("midbeat strobe", 32'(bus.mcu_bus_clock), 32'd0);
    checkOutput("midbeat oe", 32'(bus.mcu_bus_oe), 32'd0);
    checkOutput("midbeat beat_count", 32'(beat_count), 32'd0);
    checkOutput("midbeat busy", 32'(busy), 32'd0);
    checkOutput("midbeat cmd_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    exp_count = 0;
    seen_beats.delete();
    repeat (20) @(negedge system_clock);
    relax_width = 1'b0;
    checkOutput("midbeat no replay beats", 32'(seen_beats.size()), 32'd0);
    checkOutput("midbeat beat_count after", 32'(beat_count), 32'd0);

    // Beat counter wrap from 0xFFFF
    @(negedge system_clock);
    force dut.beat_count_q = 16'hFFFF;
    @(negedge system_clock);
    release dut.beat_count_q;
    applyStimulus(1'b1, 12'h002);
    waitIdle();
    checkOutput("wrap beat_count", 32'(beat_count), 32'd0);
    exp_count = 0;

    // Back-to-back pixel stream into the receiver model
    seen_beats.delete();
    exp_beats.delete();
    for (int i = 0; i < NUM_STREAM; i++) begin
      pix = 12'(i * 37 + 5);
      exp_beats.push_back({1'b0, pix[7:0]});
      exp_beats.push_back({5'b0, pix[11:8]});
      applyStimulus(1'b0, pix);
    end
    waitIdle();
    exp_count += 2 * NUM_STREAM;
    checkOutput("stream beats", 32'(seen_beats.size()), 32'(exp_beats.size()));
    for (int i = 0; i < exp_beats.size() && i < seen_beats.size(); i++) begin
      checkOutput($sformatf("stream beat%0d", i), 32'(seen_beats[i]), 32'(exp_beats[i]));
    end
    checkOutput("stream beat_count", 32'(beat_count), 32'(exp_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
